combo_lock_param: RTL and testbench

Parametrised sequential combination lock, the next generation of the fixed 3-button/4-entry lock FSM. Accepts a sequence of `DEPTH` digits of `WIDTH` bits, opens on a full-sequence match and counts failed attempts into a timed lockout. While open, the code can be reprogrammed. It sits between the debounced button/keypad front end and the door actuator driver.

---
 rtl/combo_lock_param.sv | 167 ++++++++++++++++
 tb/tb_combo_lock_param.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_param.sv
// Parametrised sequential combination lock with failed-attempt lockout.
// Sits between the debounced keypad front end and the door actuator driver.
module combo_lock_param #(
  parameter int                         WIDTH          = 3,
  parameter int                         DEPTH          = 4,
  parameter logic [WIDTH*DEPTH-1:0]     DEFAULT_CODE   = 12'hB9D,
  parameter int                         MAX_FAIL       = 3,
  parameter int                         LOCKOUT_CYCLES = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  digit,
  input  logic                              digit_valid,
  input  logic                              relock,
  input  logic                              prog,
  output logic                              open,
  output logic                              lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count,
  output logic [$clog2(DEPTH+1)-1:0]        index
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int IW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_OPEN,
    S_PROG,
    S_LOCK
  } state_t;

  state_t                          r_state;
  logic [0:DEPTH-1][WIDTH-1:0]     r_code;
  logic [0:DEPTH-1][WIDTH-1:0]     r_shadow;
  logic [IW-1:0]                   r_index;
  logic                            r_err;
  logic [FW-1:0]                   r_fail;
  logic [CW-1:0]                   r_cnt;
  logic                            r_open;
  logic                            r_lockout;

  state_t                          w_state;
  logic [0:DEPTH-1][WIDTH-1:0]     w_code;
  logic [0:DEPTH-1][WIDTH-1:0]     w_shadow;
  logic [IW-1:0]                   w_index;
  logic                            w_err;
  logic [FW-1:0]                   w_fail;
  logic [CW-1:0]                   w_cnt;
  logic [WIDTH-1:0]                w_cur;
  logic                            w_last;
  logic                            w_hit;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_index == IW'(i)) w_cur = r_code[i];
    end
  end

  assign w_last = (r_index == IW'(DEPTH - 1));
  assign w_hit  = (digit == w_cur);

  always_comb begin
    w_state  = r_state;
    w_code   = r_code;
    w_shadow = r_shadow;
    w_index  = r_index;
    w_err    = r_err;
    w_fail   = r_fail;
    w_cnt    = r_cnt;
    unique case (r_state)
      S_ENTRY: begin
        if (relock) begin
          w_index = '0;
          w_err   = 1'b0;
        end else if (digit_valid) begin
          if (w_last) begin
            w_index = '0;
            w_err   = 1'b0;
            // Verdict only after the full sequence: no early abort
            if (!r_err && w_hit) begin
              w_state = S_OPEN;
              w_fail  = '0;
            end else if (r_fail == FW'(MAX_FAIL - 1)) begin
              w_state = S_LOCK;
              w_fail  = FW'(MAX_FAIL);
              w_cnt   = CW'(LOCKOUT_CYCLES - 1);
            end else begin
              w_fail = r_fail + 1'b1;
            end
          end else begin
            w_index = r_index + 1'b1;
            w_err   = r_err | ~w_hit;
          end
        end
      end
      S_OPEN: begin
        if (relock) begin
          w_state = S_ENTRY;
        end else if (prog) begin
          w_state = S_PROG;
          w_index = '0;
        end
      end
      S_PROG: begin
        if (relock) begin
          w_state = S_ENTRY;
          w_index = '0;
        end else if (digit_valid) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (r_index == IW'(i)) w_shadow[i] = digit;
          end
          if (w_last) begin
            w_code  = w_shadow;
            w_state = S_ENTRY;
            w_index = '0;
          end else begin
            w_index = r_index + 1'b1;
          end
        end
      end
      S_LOCK: begin
        // Counter holds remaining cycles minus one
        if (r_cnt == '0) begin
          w_state = S_ENTRY;
          w_fail  = '0;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state = S_ENTRY;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_ENTRY;
      r_code    <= DEFAULT_CODE;
      r_shadow  <= '0;
      r_index   <= '0;
      r_err     <= 1'b0;
      r_fail    <= '0;
      r_cnt     <= '0;
      r_open    <= 1'b0;
      r_lockout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_code    <= w_code;
      r_shadow  <= w_shadow;
      r_index   <= w_index;
      r_err     <= w_err;
      r_fail    <= w_fail;
      r_cnt     <= w_cnt;
      r_open    <= (w_state == S_OPEN);
      r_lockout <= (w_state == S_LOCK);
    end
  end

  assign open       = r_open;
  assign lockout    = r_lockout;
  assign fail_count = r_fail;
  assign index      = r_index;

endmodule

// File: tb/tb_combo_lock_param.sv
// Scoreboard bench for combo_lock_param: per-cycle expected outputs
// from a sequence-level reference model, checked by a separate monitor.
module tb_combo_lock_param;

  localparam int W  = 3;
  localparam int D  = 4;
  localparam int MF = 3;
  localparam int LC = 16;
  localparam logic [11:0] DC = 12'hB9D;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] digit = '0;
  logic         digit_valid = 1'b0;
  logic         relock = 1'b0;
  logic         prog = 1'b0;
  logic         open;
  logic         lockout;
  logic [1:0]   fail_count;
  logic [2:0]   index;

  combo_lock_param #(
    .WIDTH(W), .DEPTH(D), .DEFAULT_CODE(DC),
    .MAX_FAIL(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clock(clock), .reset(reset), .digit(digit),
    .digit_valid(digit_valid), .relock(relock), .prog(prog),
    .open(open), .lockout(lockout),
    .fail_count(fail_count), .index(index)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       op;
    logic       lk;
    logic [1:0] fc;
    logic [2:0] ix;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   sweep = 0;
  bit   prev_open = 0;
  int   n_open = 0;

  // Reference model: mode 0 entry, 1 open, 2 program, 3 lockout
  int m_mode;
  int m_code[D];
  int m_buf[$];
  int m_fails;
  int m_left;

  function automatic void m_reset();
    int dc = int'(DC);
    m_mode = 0;
    for (int i = 0; i < D; i++) m_code[i] = (dc >> (W * (D - 1 - i))) % 8;
    m_buf.delete();
    m_fails = 0;
    m_left = 0;
  endfunction

  function automatic void m_step(bit dv, int d, bit rl, bit pg);
    bit ok;
    case (m_mode)
      0: begin
        if (rl) m_buf.delete();
        else if (dv) begin
          m_buf.push_back(d);
          if (m_buf.size() == D) begin
            ok = 1;
            for (int i = 0; i < D; i++) if (m_buf[i] != m_code[i]) ok = 0;
            m_buf.delete();
            if (ok) begin
              m_mode = 1;
              m_fails = 0;
            end else begin
              m_fails++;
              if (m_fails == MF) begin
                m_mode = 3;
                m_left = LC;
              end
            end
          end
        end
      end
      1: begin
        if (rl) m_mode = 0;
        else if (pg) begin
          m_mode = 2;
          m_buf.delete();
        end
      end
      2: begin
        if (rl) begin
          m_mode = 0;
          m_buf.delete();
        end else if (dv) begin
          m_buf.push_back(d);
          if (m_buf.size() == D) begin
            for (int i = 0; i < D; i++) m_code[i] = m_buf[i];
            m_buf.delete();
            m_mode = 0;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0;
          m_fails = 0;
        end
      end
    endcase
  endfunction

  function automatic exp_t m_exp();
    exp_t x;
    x.op = (m_mode == 1);
    x.lk = (m_mode == 3);
    x.fc = 2'(m_fails);
    x.ix = 3'(m_buf.size());
    return x;
  endfunction

  task automatic cyc(bit dv, int d, bit rl, bit pg);
    @(negedge clock);
    reset = 1'b0;
    digit_valid = dv;
    digit = W'(d);
    relock = rl;
    prog = pg;
    m_step(dv, d, rl, pg);
    sbq.push_back(m_exp());
  endtask

  task automatic rst(bit dv, int d);
    @(negedge clock);
    reset = 1'b1;
    digit_valid = dv;
    digit = W'(d);
    relock = 1'b0;
    prog = 1'b0;
    m_reset();
    sbq.push_back(m_exp());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic enter_code(input logic [11:0] c);
    for (int i = 0; i < D; i++) cyc(1, int'(c[11-3*i -: 3]), 0, 0);
  endtask

  task automatic look();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sweep && open && !prev_open) n_open++;
      prev_open = open;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if ({open, lockout, fail_count, index} !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got o=%b l=%b f=%0d i=%0d exp o=%b l=%b f=%0d i=%0d",
                   $time, open, lockout, fail_count, index,
                   e.op, e.lk, e.fc, e.ix);
        end
      end
    end
  end

  initial begin
    m_reset();
    rst(0, 0);
    rst(0, 0);
    look();
    chk("reset_open", int'(open), 0);
    chk("reset_index", int'(index), 0);

    enter_code(DC);
    look();
    chk("default_open", int'(open), 1);
    chk("default_fail", int'(fail_count), 0);
    cyc(0, 0, 1, 0);
    look();
    chk("relock_open", int'(open), 0);

    enter_code(12'b101111011101);
    look();
    chk("wrong_open", int'(open), 0);
    chk("wrong_fail", int'(fail_count), 1);
    enter_code(12'b101111011101);
    enter_code(12'b000000000000);
    look();
    chk("lockout_rise", int'(lockout), 1);
    for (int i = 0; i < LC - 1; i++) cyc(1, m_code[i % D], 0, 0);
    look();
    chk("lockout_hold", int'(lockout), 1);
    cyc(1, 5, 1, 0);
    look();
    chk("lockout_fall", int'(lockout), 0);
    chk("lockout_fail_clr", int'(fail_count), 0);
    enter_code(DC);
    look();
    chk("post_lock_open", int'(open), 1);
    cyc(0, 0, 1, 0);

    enter_code(12'o7777);
    enter_code(12'o1234);
    enter_code(DC);
    look();
    chk("two_wrong_open", int'(open), 1);
    chk("two_wrong_fail", int'(fail_count), 0);
    cyc(0, 0, 1, 0);
    enter_code(12'o0000);
    look();
    chk("single_fail_nolock", int'(lockout), 0);
    enter_code(DC);
    cyc(0, 0, 0, 1);
    enter_code(12'o0123);
    look();
    chk("prog_locked", int'(open), 0);
    enter_code(DC);
    look();
    chk("old_code_fail", int'(fail_count), 1);
    enter_code(12'o0123);
    look();
    chk("new_code_open", int'(open), 1);

    cyc(0, 0, 0, 1);
    cyc(1, 7, 0, 0);
    cyc(1, 6, 0, 0);
    cyc(0, 0, 1, 0);
    enter_code(12'o0123);
    look();
    chk("abort_keeps_code", int'(open), 1);
    cyc(0, 0, 1, 1);
    look();
    chk("relock_beats_prog", int'(open), 0);
    enter_code(12'o0123);

    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    rst(1, 3);
    look();
    chk("rst_prog_open", int'(open), 0);
    chk("rst_prog_index", int'(index), 0);
    enter_code(DC);
    look();
    chk("rst_default_code", int'(open), 1);
    cyc(0, 0, 1, 0);
    enter_code(12'o0);
    enter_code(12'o0);
    enter_code(12'o0);
    idle(5);
    rst(0, 0);
    look();
    chk("rst_lock_lockout", int'(lockout), 0);
    chk("rst_lock_fail", int'(fail_count), 0);
    idle(1);

    sweep = 1;
    for (int v = 0; v < 4096; v++) begin
      enter_code(12'(v));
      if (m_mode == 1) cyc(0, 0, 1, 0);
      while (m_mode == 3) cyc(0, 0, 0, 0);
    end
    idle(1);
    look();
    sweep = 0;
    chk("sweep_opens", n_open, 1);

    for (int n = 0; n < 3000; n++) begin
      int d;
      bit dv, rl, pg;
      dv = ($urandom % 2) == 0;
      rl = ($urandom % 16) == 0;
      pg = ($urandom % 6) == 0;
      d = int'($urandom % 8);
      if (m_mode == 0 && ($urandom % 4) != 0) d = m_code[m_buf.size()];
      if (($urandom % 400) == 0) rst(dv, d);
      else cyc(dv, d, rl, pg);
    end
    idle(2);
    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
